pwm_channel_ctrl: RTL and testbench
===================================

Name: pwm_channel_ctrl

Overview:
- Per-channel sequencer for the PWM compare path.
- Owns the shadow copies of the start/end compare values and drives them into the channel comparator.
- Consumes the comparator's registered equality/greater-than flags and runs the channel FSM, which produces the PWM waveform and event pulses.
- Sits between the register bank / counter (UEV source) and the channel output pin.

Parameters:
- CMP_WIDTH, 16, width of compare values; must match the comparator and counter.

Ports:
- clk_psc_i  in  1  prescaler clock; all logic is on its rising edge
- rst_i  in  1  asynchronous, active-high reset
- en_i  in  1  channel enable from the register bank (level)
- pol_i  in  1  output polarity: 0 = active-high, 1 = active-low
- preload_en_i  in  1  1 = shadows update only on UEV; 0 = shadows track inputs every cycle
- uev_i  in  1  update event: one-cycle pulse at counter overflow/reload
- cmp_start_i  in  CMP_WIDTH  software start value
- cmp_end_i  in  CMP_WIDTH  software end value
- cnt_eq_cmp_start_i  in  1  comparator flag: CNT == start
- cnt_gt_cmp_start_i  in  1  comparator flag: CNT > start (status only)
- cnt_eq_cmp_end_i  in  1  comparator flag: CNT == end
- cnt_gt_cmp_end_i  in  1  comparator flag: CNT > end
- cmp_start_o  out  CMP_WIDTH  shadow start value to the comparator
- cmp_end_o  out  CMP_WIDTH  shadow end value to the comparator
- pwm_o  out  1  channel output after polarity is applied
- start_evt_o  out  1  one-cycle pulse on entry to ACTIVE
- end_evt_o  out  1  one-cycle pulse on exit from ACTIVE, by either route
- busy_o  out  1  1 in any state other than IDLE

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; shadows=0; pwm_o=0; start_evt_o=0; end_evt_o=0; busy_o=0.
  - After reset is released, pwm_o drives the inactive level (=pol_i) from the first clock edge.
- All outputs are registered.
- pwm_o = (next_state==ACTIVE) XOR pol_i, so it changes on the same edge the state changes.
- Shadow update:
  - preload_en_i=0: shadow <= input on every edge (1-cycle latency).
  - preload_en_i=1: shadow <= input only on edges where uev_i=1.
  - The SYNC->ARMED transition always loads the shadows.
- FSM states: IDLE, SYNC, ARMED, ACTIVE, HOLD (plus DONE with the optional feature).
- IDLE:
  - en_i=1 -> SYNC.
  - Output inactive.
- SYNC:
  - uev_i=1 -> ARMED and load the shadows.
  - The channel never starts mid-period.
- ARMED:
  - eq_start=1, eq_end=0 -> ACTIVE; start_evt_o=1.
  - eq_start=1, eq_end=1 (start==end) -> stay ARMED; 0% duty; no events.
  - uev_i=1 -> stay ARMED.
- ACTIVE:
  - eq_end=1 or gt_end=1 -> HOLD; end_evt_o=1. The gt_end term covers an end value lowered below CNT.
  - uev_i=1 before an end match -> ARMED; end_evt_o=1. The pulse is truncated at the period boundary (end > period).
  - If both occur in the same cycle, uev_i wins and the end-match exit is not taken separately: -> ARMED, single end_evt_o.
- HOLD:
  - uev_i=1 -> ARMED.
- en_i=0 in any state:
  - -> IDLE on the next edge; output inactive.
  - end_evt_o pulses if the state was ACTIVE.
  - Shadows are held.
- Comparator flags are one cycle behind CNT. The controller acts on flags as presented; the total CNT-to-pin latency is 1 (comparator) + 1 (this block).
- gt_start is unused by the FSM. It is ignored.
- Start > end with no truncation: ARMED at start, then gt_end exits on the next cycle. The result is a 1-cycle pulse with start_evt_o and end_evt_o on consecutive cycles.
- Toggling pol_i takes effect on the next edge; the state is unaffected.

Optional Feature:
- Macro: PWM_ONE_PULSE_EN.
- Defined:
  - Adds input port opm_i (1 bit) and state DONE.
  - HOLD on uev_i with opm_i=1 -> DONE.
  - ACTIVE truncated by uev_i with opm_i=1 -> DONE.
  - DONE holds the output inactive, ignores flags and uev_i, and keeps busy_o=1. It exits only via en_i=0 -> IDLE.
- Undefined: no opm_i port, no DONE state; HOLD always returns to ARMED on uev_i.

Test Plan:
- Reset mid-ACTIVE with rst_i=1 -> pwm_o=0, shadows=0, busy_o=0 immediately (async). After release with pol_i=1 -> pwm_o=1 on the first edge.
- preload_en_i=1, start=3, end=7, counter period 10, en_i=1 -> SYNC until UEV. Each period: pwm_o is high on the edge eq_start is seen and low on the edge eq_end is seen, i.e. 4 cycles. start_evt_o/end_evt_o pulse once each per period.
- preload_en_i=1, write start=5 mid-period -> cmp_start_o stays 3 until the next uev_i, then becomes 5. With preload_en_i=0 it changes on the next edge.
- start=end=4 -> pwm_o never active, no events. Then end=12 with period 10 -> pulse truncated at uev_i; ARMED; end_evt_o=1 exactly once.
- ACTIVE with eq_end and uev_i in the same cycle -> state ARMED, single end_evt_o pulse. en_i=0 during ACTIVE -> IDLE, pwm_o inactive, end_evt_o=1.
- PWM_ONE_PULSE_EN defined, opm_i=1, start=2, end=5 -> exactly one 3-cycle pulse, then DONE with busy_o=1 across 3 further UEVs. en_i=0 -> IDLE.

Source files
------------

// File: rtl/pwm_channel_ctrl.sv
// pwm_channel_ctrl: per-channel PWM sequencer (shadow compare values + channel FSM)
//
// Ports:
//   clk_psc_i          prescaler clock, rising edge
//   rst_i              asynchronous active-high reset
//   en_i               channel enable (level)
//   pol_i              output polarity, 0 = active-high, 1 = active-low
//   preload_en_i       1 = shadows load only on uev_i, 0 = shadows track inputs
//   uev_i              update event pulse at counter overflow/reload
//   opm_i              one-pulse mode (only with PWM_ONE_PULSE_EN defined)
//   cmp_start_i/_end_i software compare values
//   cnt_*_i            registered comparator flags (one cycle behind CNT)
//   cmp_start_o/_end_o shadow compare values to the comparator
//   pwm_o              channel output after polarity
//   start_evt_o        pulse on entry to ACTIVE
//   end_evt_o          pulse on exit from ACTIVE
//   busy_o             channel is not IDLE
//
// Optional feature macro: PWM_ONE_PULSE_EN adds opm_i and the DONE state.
module pwm_channel_ctrl #(
    parameter int CMP_WIDTH = 16
) (
    input  logic                 clk_psc_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 pol_i,
    input  logic                 preload_en_i,
    input  logic                 uev_i,
`ifdef PWM_ONE_PULSE_EN
    input  logic                 opm_i,
`endif
    input  logic [CMP_WIDTH-1:0] cmp_start_i,
    input  logic [CMP_WIDTH-1:0] cmp_end_i,
    input  logic                 cnt_eq_cmp_start_i,
    input  logic                 cnt_gt_cmp_start_i,
    input  logic                 cnt_eq_cmp_end_i,
    input  logic                 cnt_gt_cmp_end_i,
    output logic [CMP_WIDTH-1:0] cmp_start_o,
    output logic [CMP_WIDTH-1:0] cmp_end_o,
    output logic                 pwm_o,
    output logic                 start_evt_o,
    output logic                 end_evt_o,
    output logic                 busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_ARMED,
        S_ACTIVE,
        S_HOLD
`ifdef PWM_ONE_PULSE_EN
        , S_DONE
`endif
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    state_t                 w_rearm;
    logic                   w_load;
    logic                   w_unused;
    logic [CMP_WIDTH-1:0]   r_cmp_start;
    logic [CMP_WIDTH-1:0]   r_cmp_end;
    logic                   r_pwm;
    logic                   r_start_evt;
    logic                   r_end_evt;
    logic                   r_busy;

    // CNT > start is status only; the sequencer never looks at it
    assign w_unused = cnt_gt_cmp_start_i;

    // Shadows freeze while disabled; uev_i covers the SYNC->ARMED load too
    assign w_load = en_i && (!preload_en_i || uev_i);

`ifdef PWM_ONE_PULSE_EN
    assign w_rearm = opm_i ? S_DONE : S_ARMED;
`else
    assign w_rearm = S_ARMED;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_SYNC;
            S_SYNC:   w_next = uev_i ? S_ARMED : S_SYNC;
            // start==end gives 0% duty: both flags together keep us armed
            S_ARMED:  w_next = (cnt_eq_cmp_start_i && !cnt_eq_cmp_end_i) ? S_ACTIVE : S_ARMED;
            // period boundary wins over an end match in the same cycle
            S_ACTIVE: w_next = uev_i ? w_rearm :
                               (cnt_eq_cmp_end_i || cnt_gt_cmp_end_i) ? S_HOLD : S_ACTIVE;
            S_HOLD:   w_next = uev_i ? w_rearm : S_HOLD;
`ifdef PWM_ONE_PULSE_EN
            S_DONE:   w_next = S_DONE;
`endif
            default:  w_next = S_IDLE;
        endcase
        if (!en_i)
            w_next = S_IDLE;
    end

    always_ff @(posedge clk_psc_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cmp_start <= '0;
            r_cmp_end   <= '0;
            r_pwm       <= 1'b0;
            r_start_evt <= 1'b0;
            r_end_evt   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next;
            if (w_load) begin
                r_cmp_start <= cmp_start_i;
                r_cmp_end   <= cmp_end_i;
            end
            r_pwm       <= (w_next == S_ACTIVE) ^ pol_i;
            r_start_evt <= (w_next == S_ACTIVE) && (r_state != S_ACTIVE);
            r_end_evt   <= (r_state == S_ACTIVE) && (w_next != S_ACTIVE);
            r_busy      <= (w_next != S_IDLE);
        end
    end

    assign cmp_start_o = r_cmp_start;
    assign cmp_end_o   = r_cmp_end;
    assign pwm_o       = r_pwm;
    assign start_evt_o = r_start_evt;
    assign end_evt_o   = r_end_evt;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_pwm_channel_ctrl.sv
// tb_pwm_channel_ctrl: randomized and scenario bench for pwm_channel_ctrl against a reference model
module tb_pwm_channel_ctrl;
    localparam int W = 16;
    localparam int IDLE = 0, SYNC = 1, ARMED = 2, ACTIVE = 3, HOLD = 4, DONE = 5;

    logic clk = 1'b0;
    logic rst, en, pol, pre, uev, eqs, gts, eqe, gte, opm;
    logic [W-1:0] cs_i, ce_i, cs_o, ce_o;
    logic pwm, sevt, eevt, busy;

    pwm_channel_ctrl #(.CMP_WIDTH(W)) dut (
        .clk_psc_i(clk), .rst_i(rst), .en_i(en), .pol_i(pol), .preload_en_i(pre), .uev_i(uev),
`ifdef PWM_ONE_PULSE_EN
        .opm_i(opm),
`endif
        .cmp_start_i(cs_i), .cmp_end_i(ce_i),
        .cnt_eq_cmp_start_i(eqs), .cnt_gt_cmp_start_i(gts),
        .cnt_eq_cmp_end_i(eqe), .cnt_gt_cmp_end_i(gte),
        .cmp_start_o(cs_o), .cmp_end_o(ce_o), .pwm_o(pwm),
        .start_evt_o(sevt), .end_evt_o(eevt), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int m_st;
    logic [W-1:0] m_cs, m_ce;
    logic m_pwm, m_sevt, m_eevt, m_busy;
    int cnt, cnt_d, per;
    int act, ns, ne;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = IDLE; m_cs = '0; m_ce = '0;
        m_pwm = 0; m_sevt = 0; m_eevt = 0; m_busy = 0;
    endtask

    // Channel rules evaluated on the inputs present at a rising edge
    task automatic model_edge();
        int nx;
        nx = m_st;
        if (!en) nx = IDLE;
        else if (m_st == IDLE) nx = SYNC;
        else if (m_st == SYNC && uev) nx = ARMED;
        else if (m_st == ARMED && eqs && !eqe) nx = ACTIVE;
        else if ((m_st == ACTIVE || m_st == HOLD) && uev) nx = opm ? DONE : ARMED;
        else if (m_st == ACTIVE && (eqe || gte)) nx = HOLD;
        if (en && (!pre || uev)) begin
            m_cs = cs_i;
            m_ce = ce_i;
        end
        m_sevt = (nx == ACTIVE) && (m_st != ACTIVE);
        m_eevt = (m_st == ACTIVE) && (nx != ACTIVE);
        m_pwm  = (nx == ACTIVE) ^ pol;
        m_busy = (nx != IDLE);
        m_st   = nx;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("pwm", pwm, m_pwm);
        chk("start_evt", sevt, m_sevt);
        chk("end_evt", eevt, m_eevt);
        chk("busy", busy, m_busy);
        chk("cmp_start", cs_o, m_cs);
        chk("cmp_end", ce_o, m_ce);
        if (pwm != pol) act++;
        if (sevt) ns++;
        if (eevt) ne++;
    endtask

    // Free-running counter with a registered comparator in front of the DUT
    task automatic tick();
        uev = (cnt == 0);
        eqs = (cnt_d == int'(m_cs));
        gts = (cnt_d > int'(m_cs));
        eqe = (cnt_d == int'(m_ce));
        gte = (cnt_d > int'(m_ce));
        step();
        cnt_d = cnt;
        cnt = (cnt + 1) % per;
    endtask

    task automatic align();
        int k;
        k = 0;
        while (cnt != 0 && k < 20) begin tick(); k++; end
        tick();
    endtask

    task automatic tally(input int n);
        act = 0; ns = 0; ne = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic raw(input logic u, input logic s, input logic e);
        uev = u; eqs = s; gts = 0; eqe = e; gte = 0;
        step();
    endtask

    task automatic arm();
        int k;
        k = 0;
        while (m_st != ARMED && k < 40) begin tick(); k++; end
        chk("arm_timeout", m_st, ARMED);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1;
        #1;
        chk({tag, "_pwm"}, pwm, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cs"}, cs_o, 0);
        chk({tag, "_ce"}, ce_o, 0);
        model_reset();
        #1 rst = 0;
    endtask

    initial begin
        rst = 1; en = 0; pol = 0; pre = 1; uev = 0; opm = 0;
        eqs = 0; gts = 0; eqe = 0; gte = 0;
        cs_i = 3; ce_i = 7;
        cnt = 0; cnt_d = 0; per = 10;
        model_reset();
        #2;
        chk("rst_pwm", pwm, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sevt", sevt, 0);
        chk("rst_eevt", eevt, 0);
        #5 rst = 0;
        pol = 1;
        step();
        chk("rel_pol_pwm", pwm, 1);
        pol = 0;

        en = 1;
        arm();
        tally(50);
        chk("p37_active", act, 20);
        chk("p37_starts", ns, 5);
        chk("p37_ends", ne, 5);

        cs_i = 5;
        tick();
        chk("preload_hold", cs_o, 3);
        align();
        chk("preload_uev", cs_o, 5);
        pre = 0; cs_i = 3;
        tick();
        chk("track_next", cs_o, 3);
        pre = 1;

        cs_i = 4; ce_i = 4;
        align();
        tally(20);
        chk("eq_active", act, 0);
        chk("eq_starts", ns, 0);
        chk("eq_ends", ne, 0);
        ce_i = 12;
        align();
        tally(20);
        chk("trunc_active", act, 10);
        chk("trunc_starts", ns, 2);
        chk("trunc_ends", ne, 2);

        raw(0, 1, 0);
        chk("d_sevt", sevt, 1);
        raw(1, 0, 1);
        chk("d_both_eevt", eevt, 1);
        raw(0, 0, 0);
        chk("d_single_eevt", eevt, 0);
        chk("d_inactive", pwm, 0);
        raw(0, 1, 0);
        en = 0;
        raw(0, 0, 0);
        chk("dis_eevt", eevt, 1);
        chk("dis_busy", busy, 0);
        chk("dis_pwm", pwm, 0);

        en = 1;
        raw(0, 0, 0);
        raw(1, 0, 0);
        raw(0, 1, 0);
        async_reset("midact");
        pol = 1;
        en = 0;
        step();
        chk("midact_rel_pwm", pwm, 1);
        pol = 0;

`ifdef PWM_ONE_PULSE_EN
        opm = 1; en = 1; cs_i = 2; ce_i = 5; cnt = 0; cnt_d = 0;
        arm();
        tally(40);
        chk("opm_active", act, 3);
        chk("opm_starts", ns, 1);
        chk("opm_ends", ne, 1);
        chk("opm_busy", busy, 1);
        en = 0;
        tick();
        chk("opm_exit_busy", busy, 0);
        opm = 0;
`endif

        for (int i = 0; i < 2000; i++) begin
            en  = ($urandom_range(15) != 0);
            if ($urandom_range(31) == 0) pol = ~pol;
            if ($urandom_range(15) == 0) pre = $urandom_range(1);
`ifdef PWM_ONE_PULSE_EN
            if ($urandom_range(63) == 0) opm = $urandom_range(1);
`endif
            if ($urandom_range(7) == 0) cs_i = W'($urandom_range(15));
            if ($urandom_range(7) == 0) ce_i = W'($urandom_range(15));
            uev = ($urandom_range(7) == 0);
            eqs = ($urandom_range(3) == 0);
            gts = $urandom_range(1);
            eqe = ($urandom_range(3) == 0);
            gte = ($urandom_range(5) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
